// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a registered ID/EX word.
// Define DECODE_DEBUG_INSTR_EN to carry the raw instruction in instr_data.
package rv32i_pkg;
    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        f3_add = 3'b000, f3_sll = 3'b001, f3_slt = 3'b010, f3_sltu = 3'b011,
        f3_xor = 3'b100, f3_sr  = 3'b101, f3_or  = 3'b110, f3_and  = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        beq  = 3'b000, bne  = 3'b001, blt  = 3'b100,
        bge  = 3'b101, bltu = 3'b110, bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
        alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
    } alu_ops;

    typedef enum logic {am1_rs1 = 1'b0, am1_pc = 1'b1} alumux1_sel_t;
    typedef enum logic {am2_imm = 1'b0, am2_rs2 = 1'b1} alumux2_sel_t;
    typedef enum logic {cm_rs2 = 1'b0, cm_imm = 1'b1} cmpmux_sel_t;
    typedef enum logic {exo_alu = 1'b0, exo_cmp = 1'b1} exoutmux_sel_t;

    typedef enum logic [2:0] {
        rf_alu_out = 3'd0, rf_u_imm = 3'd1, rf_lw  = 3'd2, rf_pc_plus4 = 3'd3,
        rf_lb      = 3'd4, rf_lbu   = 3'd5, rf_lh  = 3'd6, rf_lhu      = 3'd7
    } regfilemux_sel_t;

    typedef enum logic [1:0] {
        fwd_none = 2'd0, fwd_ex = 2'd1, fwd_mem = 2'd2, fwd_wb = 2'd3
    } fwdmux_sel_t;

    typedef struct packed {
        logic [6:0]      opcode;
        alu_ops          aluop;
        branch_funct3_t  cmpop;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      load_funct3;
        logic [2:0]      store_funct3;
        logic            regfile_load;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        cmpmux_sel_t     cmpmux_sel;
        regfilemux_sel_t regfilemux_sel;
        exoutmux_sel_t   EX_alu_out_mux_sel;
        fwdmux_sel_t     fwd_rs1_sel;
        fwdmux_sel_t     fwd_rs2_sel;
    } rv32i_ctrl_t;

    typedef struct packed {
        logic [31:0] instr_data;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] immediate;
        rv32i_ctrl_t ctrl;
    } rv32i_instr_word;
endpackage

module decode_stage
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output rv32i_instr_word id_instr_word
);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic        is_load, is_store, is_imm, is_reg;
    logic        hazard, accept;
    logic        valid_q, valid_d;
    rv32i_instr_word dec, word_q, word_d;

    assign opc   = if_instr[6:0];
    assign f3    = if_instr[14:12];
    assign imm_i = {{21{if_instr[31]}}, if_instr[30:20]};
    assign imm_s = {{21{if_instr[31]}}, if_instr[30:25], if_instr[11:7]};
    assign imm_b = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'h000};
    assign imm_j = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};

    assign is_lui   = (opc == op_lui);
    assign is_auipc = (opc == op_auipc);
    assign is_jal   = (opc == op_jal);
    assign is_jalr  = (opc == op_jalr);
    assign is_br    = (opc == op_br);
    assign is_load  = (opc == op_load);
    assign is_store = (opc == op_store);
    assign is_imm   = (opc == op_imm);
    assign is_reg   = (opc == op_reg);

    always_comb begin
        dec = '0;
        dec.pc = if_pc;
        dec.rd = if_instr[11:7];
        dec.ctrl.opcode = opc;
        dec.ctrl.aluop = alu_add;
        dec.ctrl.cmpop = beq;
        dec.ctrl.fwd_rs1_sel = fwd_none;
        dec.ctrl.fwd_rs2_sel = fwd_none;
`ifdef DECODE_DEBUG_INSTR_EN
        dec.instr_data = if_instr;
`endif
        unique case (1'b1)
            is_lui: begin
                dec.immediate = imm_u;
                dec.ctrl.regfilemux_sel = rf_u_imm;
                dec.ctrl.regfile_load = 1'b1;
            end
            is_auipc: begin
                dec.immediate = imm_u;
                dec.ctrl.alumux1_sel = am1_pc;
                dec.ctrl.regfile_load = 1'b1;
            end
            is_jal: begin
                dec.immediate = imm_j;
                dec.ctrl.alumux1_sel = am1_pc;
                dec.ctrl.regfilemux_sel = rf_pc_plus4;
                dec.ctrl.regfile_load = 1'b1;
            end
            is_jalr: begin
                dec.rs1 = if_instr[19:15];
                dec.immediate = imm_i;
                dec.ctrl.regfilemux_sel = rf_pc_plus4;
                dec.ctrl.regfile_load = 1'b1;
            end
            is_br: begin
                dec.rs1 = if_instr[19:15];
                dec.rs2 = if_instr[24:20];
                dec.immediate = imm_b;
                dec.ctrl.cmpop = branch_funct3_t'(f3);
                dec.ctrl.alumux1_sel = am1_pc;
            end
            is_load: begin
                dec.rs1 = if_instr[19:15];
                dec.immediate = imm_i;
                dec.ctrl.mem_read = 1'b1;
                dec.ctrl.load_funct3 = f3;
                dec.ctrl.regfile_load = 1'b1;
                case (f3)
                    3'b000:  dec.ctrl.regfilemux_sel = rf_lb;
                    3'b001:  dec.ctrl.regfilemux_sel = rf_lh;
                    3'b100:  dec.ctrl.regfilemux_sel = rf_lbu;
                    3'b101:  dec.ctrl.regfilemux_sel = rf_lhu;
                    default: dec.ctrl.regfilemux_sel = rf_lw;
                endcase
            end
            is_store: begin
                dec.rs1 = if_instr[19:15];
                dec.rs2 = if_instr[24:20];
                dec.immediate = imm_s;
                dec.ctrl.mem_write = 1'b1;
                dec.ctrl.store_funct3 = f3;
            end
            is_imm, is_reg: begin
                dec.rs1 = if_instr[19:15];
                dec.immediate = is_reg ? 32'h0 : imm_i;
                dec.ctrl.regfile_load = 1'b1;
                dec.ctrl.cmpmux_sel = is_reg ? cm_rs2 : cm_imm;
                dec.ctrl.aluop = alu_ops'(f3);
                if (is_reg) begin
                    dec.rs2 = if_instr[24:20];
                    dec.ctrl.alumux2_sel = am2_rs2;
                end
                // srai shares bit30 with sra; sub exists only in the reg form
                if (f3 == f3_sr)
                    dec.ctrl.aluop = if_instr[30] ? alu_sra : alu_srl;
                if (f3 == f3_add && is_reg && if_instr[30])
                    dec.ctrl.aluop = alu_sub;
                if (f3 == f3_slt || f3 == f3_sltu) begin
                    dec.ctrl.cmpop = (f3 == f3_slt) ? blt : bltu;
                    dec.ctrl.EX_alu_out_mux_sel = exo_cmp;
                end
            end
            default: ;
        endcase
        if (dec.rd == 5'd0)
            dec.ctrl.regfile_load = 1'b0;
    end

    assign hazard = valid_q & word_q.ctrl.mem_read & (word_q.rd != 5'd0)
                  & id_ready & if_valid
                  & ((dec.rs1 == word_q.rd) | (dec.rs2 == word_q.rd));

    assign if_ready = rst_n & (~valid_q | id_ready) & ~hazard & ~flush;
    assign accept   = if_valid & if_ready;

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            word_d  = dec;
        end else if (id_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign id_valid      = valid_q;
    assign id_instr_word = word_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode table plus
// hazard, stall, flush and reset sequences.
module tb_decode_stage;
    import rv32i_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [31:0]     if_pc;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    rv32i_instr_word id_instr_word;

    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;
    logic mw_seen = 1'b0;

    decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr_word (id_instr_word)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (mon_en && id_valid && id_instr_word.ctrl.mem_write)
            mw_seen = 1'b1;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  aluop;
        logic [2:0]  cmpop;
        logic        rl;
        logic        mr;
        logic        mw;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h00500093, 32'h40, 5'd1,  5'd0, 5'd0, 32'h5,        3'd0, 3'd0, 1, 0, 0};
        tbl[1]  = '{32'hFE000EE3, 32'h44, 5'd29, 5'd0, 5'd0, 32'hFFFFFFFC, 3'd0, 3'd0, 0, 0, 0};
        tbl[2]  = '{32'h0020A223, 32'h48, 5'd4,  5'd1, 5'd2, 32'h4,        3'd0, 3'd0, 0, 0, 1};
        tbl[3]  = '{32'h0000A103, 32'h4C, 5'd2,  5'd1, 5'd0, 32'h0,        3'd0, 3'd0, 1, 1, 0};
        tbl[4]  = '{32'h407302B3, 32'h50, 5'd5,  5'd6, 5'd7, 32'h0,        3'd3, 3'd0, 1, 0, 0};
        tbl[5]  = '{32'h40325213, 32'h54, 5'd4,  5'd4, 5'd0, 32'h403,      3'd2, 3'd0, 1, 0, 0};
        tbl[6]  = '{32'hFFF4A413, 32'h58, 5'd8,  5'd9, 5'd0, 32'hFFFFFFFF, 3'd2, 3'd4, 1, 0, 0};
        tbl[7]  = '{32'h12345537, 32'h5C, 5'd10, 5'd0, 5'd0, 32'h12345000, 3'd0, 3'd0, 1, 0, 0};
        tbl[8]  = '{32'h0080006F, 32'h60, 5'd0,  5'd0, 5'd0, 32'h8,        3'd0, 3'd0, 0, 0, 0};
        tbl[9]  = '{32'h00000000, 32'h64, 5'd0,  5'd0, 5'd0, 32'h0,        3'd0, 3'd0, 0, 0, 0};
        tbl[10] = '{32'h002101B3, 32'h68, 5'd3,  5'd2, 5'd2, 32'h0,        3'd0, 3'd0, 1, 0, 0};
        tbl[11] = '{32'h003130B3, 32'h6C, 5'd1,  5'd2, 5'd3, 32'h0,        3'd3, 3'd6, 1, 0, 0};

        rst_n = 1'b0;
        if_valid = 1'b0;
        if_instr = 32'h0;
        if_pc = 32'h0;
        flush = 1'b0;
        id_ready = 1'b1;

        #12;
        chk("reset id_valid", 32'(id_valid), 32'd0);
        chk("reset if_ready", 32'(if_ready), 32'd0);
        chk("reset word zero", 32'(id_instr_word == '0), 32'd1);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            if_instr = tbl[i].instr;
            if_pc = tbl[i].pc;
            if_valid = 1'b1;
            #1;
            chk($sformatf("v%0d if_ready", i), 32'(if_ready), 32'd1);
            tick();
            if_valid = 1'b0;
            chk($sformatf("v%0d valid", i), 32'(id_valid), 32'd1);
            chk($sformatf("v%0d pc", i), id_instr_word.pc, tbl[i].pc);
            chk($sformatf("v%0d rd", i), 32'(id_instr_word.rd), 32'(tbl[i].rd));
            chk($sformatf("v%0d rs1", i), 32'(id_instr_word.rs1), 32'(tbl[i].rs1));
            chk($sformatf("v%0d rs2", i), 32'(id_instr_word.rs2), 32'(tbl[i].rs2));
            chk($sformatf("v%0d imm", i), id_instr_word.immediate, tbl[i].imm);
            chk($sformatf("v%0d aluop", i), 32'(id_instr_word.ctrl.aluop), 32'(tbl[i].aluop));
            chk($sformatf("v%0d cmpop", i), 32'(id_instr_word.ctrl.cmpop), 32'(tbl[i].cmpop));
            chk($sformatf("v%0d regfile_load", i), 32'(id_instr_word.ctrl.regfile_load), 32'(tbl[i].rl));
            chk($sformatf("v%0d mem_read", i), 32'(id_instr_word.ctrl.mem_read), 32'(tbl[i].mr));
            chk($sformatf("v%0d mem_write", i), 32'(id_instr_word.ctrl.mem_write), 32'(tbl[i].mw));
            chk($sformatf("v%0d opcode", i), 32'(id_instr_word.ctrl.opcode), 32'(tbl[i].instr[6:0]));
`ifdef DECODE_DEBUG_INSTR_EN
            chk($sformatf("v%0d instr_data", i), id_instr_word.instr_data, tbl[i].instr);
`else
            chk($sformatf("v%0d instr_data", i), id_instr_word.instr_data, 32'h0);
`endif
        end
        tick();
        chk("drain id_valid", 32'(id_valid), 32'd0);

        // load-use: lw x2 then add x3,x2,x2
        if_instr = 32'h0000A103;
        if_pc = 32'h100;
        if_valid = 1'b1;
        tick();
        if_instr = 32'h002101B3;
        if_pc = 32'h104;
        #1;
        chk("hz lw held", 32'(id_valid), 32'd1);
        chk("hz if_ready", 32'(if_ready), 32'd0);
        tick();
        chk("hz bubble valid", 32'(id_valid), 32'd0);
        chk("hz retry if_ready", 32'(if_ready), 32'd1);
        tick();
        if_valid = 1'b0;
        chk("hz add valid", 32'(id_valid), 32'd1);
        chk("hz add rs1", 32'(id_instr_word.rs1), 32'd2);
        chk("hz add rs2", 32'(id_instr_word.rs2), 32'd2);
        chk("hz add pc", id_instr_word.pc, 32'h104);
        tick();

        // load to x0 never stalls
        if_instr = 32'h0000A003;
        if_pc = 32'h110;
        if_valid = 1'b1;
        tick();
        if_instr = 32'h000001B3;
        if_pc = 32'h114;
        #1;
        chk("x0 load if_ready", 32'(if_ready), 32'd1);
        tick();
        if_valid = 1'b0;
        chk("x0 load next rd", 32'(id_instr_word.rd), 32'd3);
        chk("x0 load next valid", 32'(id_valid), 32'd1);
        tick();

        // back-pressure holds addi for three cycles
        if_instr = 32'h00500093;
        if_pc = 32'h40;
        if_valid = 1'b1;
        tick();
        id_ready = 1'b0;
        if_instr = 32'h407302B3;
        if_pc = 32'h50;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d if_ready", c), 32'(if_ready), 32'd0);
            tick();
            chk($sformatf("stall%0d valid", c), 32'(id_valid), 32'd1);
            chk($sformatf("stall%0d rd", c), 32'(id_instr_word.rd), 32'd1);
            chk($sformatf("stall%0d imm", c), id_instr_word.immediate, 32'h5);
            chk($sformatf("stall%0d pc", c), id_instr_word.pc, 32'h40);
        end
        id_ready = 1'b1;
        tick();
        if_valid = 1'b0;
        chk("release rd", 32'(id_instr_word.rd), 32'd5);
        chk("release valid", 32'(id_valid), 32'd1);
        tick();

        // flush squashes a store that would also hit a load-use hazard
        if_instr = 32'h0000A103;
        if_pc = 32'h120;
        if_valid = 1'b1;
        tick();
        mon_en = 1'b1;
        if_instr = 32'h0020A223;
        if_pc = 32'h124;
        flush = 1'b1;
        #1;
        chk("flush if_ready", 32'(if_ready), 32'd0);
        tick();
        flush = 1'b0;
        if_valid = 1'b0;
        chk("flush id_valid", 32'(id_valid), 32'd0);
        tick();
        tick();
        chk("flush later valid", 32'(id_valid), 32'd0);
        mon_en = 1'b0;
        chk("flush no mem_write", 32'(mw_seen), 32'd0);

        // asynchronous reset mid-stream, then fetch an all-zero word
        if_instr = 32'h00500093;
        if_pc = 32'h200;
        if_valid = 1'b1;
        tick();
        if_valid = 1'b0;
        chk("pre-reset valid", 32'(id_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", 32'(id_valid), 32'd0);
        chk("async reset word", 32'(id_instr_word == '0), 32'd1);
        chk("async reset if_ready", 32'(if_ready), 32'd0);
        #2;
        if_instr = 32'h00000000;
        if_pc = 32'h80;
        if_valid = 1'b1;
        rst_n = 1'b1;
        tick();
        if_valid = 1'b0;
        chk("nop valid", 32'(id_valid), 32'd1);
        chk("nop pc", id_instr_word.pc, 32'h80);
        chk("nop regfile_load", 32'(id_instr_word.ctrl.regfile_load), 32'd0);
        chk("nop mem_read", 32'(id_instr_word.ctrl.mem_read), 32'd0);
        chk("nop mem_write", 32'(id_instr_word.ctrl.mem_write), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
